// File: rtl/sw_debounce_press.sv
// Switch conditioning: 2-flop synchroniser plus debounce per switch, and a
// lowest-index-first queue that reports colour-switch releases one per cycle.

module sw_debounce_lane #(
  parameter int unsigned DEBOUNCE_CLKS = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_lvl
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CLKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CLKS - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while s2 disagrees with the debounced level, so it
  // restarts on any return to the settled value and never wraps.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= i_raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_lvl = lvl_q;
endmodule

module sw_debounce_press #(
  parameter int unsigned CLK_PER_SEC   = 50000000,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned DEBOUNCE_CLKS = CLK_PER_SEC / 1000 * DEBOUNCE_MS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_sw,
  output logic [4:0] o_sw,
  output logic       o_dv,
  output logic [1:0] o_sw_id,
  output logic [3:0] o_pend
);
  localparam int NUM_SW     = 5;
  localparam int NUM_COLOUR = 4;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_lane
    sw_debounce_lane #(
      .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (i_sw[g]),
      .o_lvl  (o_sw[g])
    );
  end

  logic [NUM_COLOUR-1:0] lvl_prev_q;
  logic [NUM_COLOUR-1:0] fall;
  logic [NUM_COLOUR-1:0] pend_q, pend_d, pend_next, pick;
  logic                  dv_q, dv_d;
  logic [1:0]            id_q, id_d;

  // Only the colour switches raise events; the game-reset switch is level-only.
  assign fall = lvl_prev_q & ~o_sw[NUM_COLOUR-1:0];

  // New falls merge into the queue on the same edge a report drains it.
  always_comb begin
    pend_next = pend_q | fall;
    pick      = '0;
    id_d      = id_q;
    for (int b = NUM_COLOUR - 1; b >= 0; b--) begin
      if (pend_next[b]) begin
        id_d    = 2'(b);
        pick    = '0;
        pick[b] = 1'b1;
      end
    end
    dv_d   = |pend_next;
    pend_d = pend_next & ~pick;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lvl_prev_q <= '0;
      pend_q     <= '0;
      dv_q       <= 1'b0;
      id_q       <= 2'b00;
    end else begin
      lvl_prev_q <= o_sw[NUM_COLOUR-1:0];
      pend_q     <= pend_d;
      dv_q       <= dv_d;
      id_q       <= id_d;
    end
  end

  assign o_dv    = dv_q;
  assign o_sw_id = id_q;
  assign o_pend  = pend_q;
endmodule
